// File: rtl/btn_pkg.sv
// Shared types and constants for the direction-button conditioner.
package btn_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 0;

  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

  typedef enum logic [1:0] {
    ST_STABLE_LOW,
    ST_WAIT_HIGH,
    ST_STABLE_HIGH,
    ST_WAIT_LOW
  } deb_state_t;

  // Simultaneous presses resolve up > right > down > left.
  function automatic dir_t prio_dir(input logic [NUM_BTN-1:0] p);
    if (p[BTN_UP])    return DIR_UP;
    if (p[BTN_RIGHT]) return DIR_RIGHT;
    if (p[BTN_DOWN])  return DIR_DOWN;
    return DIR_LEFT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, 4-state debounce FSM with saturating counter,
// and hold-to-repeat pulses when BTN_AUTOREPEAT_EN is defined.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic press_nxt
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rise_acc;
  logic          rep_fire;

  assign s = sync_q[1];

  // The acceptance edge counts as one of the stable cycles, hence compare
  // against the incremented value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_acc = 1'b0;
    cnt_inc  = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
    case (state_q)
      ST_STABLE_LOW: if (s) begin
        state_d = ST_WAIT_HIGH;
        cnt_d   = '0;
      end
      ST_WAIT_HIGH: if (s) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_LAST) begin
          state_d  = ST_STABLE_HIGH;
          level_d  = 1'b1;
          rise_acc = 1'b1;
          cnt_d    = '0;
        end
      end else begin
        state_d = ST_STABLE_LOW;
        cnt_d   = '0;
      end
      ST_STABLE_HIGH: if (!s) begin
        state_d = ST_WAIT_LOW;
        cnt_d   = '0;
      end
      ST_WAIT_LOW: if (!s) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_LAST) begin
          state_d = ST_STABLE_LOW;
          level_d = 1'b0;
          cnt_d   = '0;
        end
      end else begin
        state_d = ST_STABLE_HIGH;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          rep_first_q, rep_first_d;

  // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD while held.
  always_comb begin
    rep_d       = '0;
    rep_first_d = 1'b0;
    rep_fire    = 1'b0;
    rep_inc     = rep_q + RW'(1);
    if (state_q == ST_STABLE_HIGH && s) begin
      rep_d       = rep_inc;
      rep_first_d = rep_first_q;
      if (rep_inc == (rep_first_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
        rep_fire    = 1'b1;
        rep_d       = '0;
        rep_first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q       <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire   = 1'b0;
`endif

  assign press_d = rise_acc | rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign press_nxt = press_d;

endmodule

// File: rtl/btn_conditioner.sv
// Four debounced direction buttons plus a priority "last direction" latch.
// Define BTN_AUTOREPEAT_EN for hold-to-repeat press pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up_raw,
  input  logic       btn_right_raw,
  input  logic       btn_down_raw,
  input  logic       btn_left_raw,
  output logic       up,
  output logic       right,
  output logic       down,
  output logic       left,
  output logic [3:0] press,
  output logic [1:0] dir,
  output logic       dir_valid
);

  logic [NUM_BTN-1:0] raw_vec, level_vec, press_nxt;

  assign raw_vec = {btn_up_raw, btn_right_raw, btn_down_raw, btn_left_raw};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_deb (
      .clk      (clk),
      .rst_n    (reset),
      .raw      (raw_vec[i]),
      .level    (level_vec[i]),
      .press    (press[i]),
      .press_nxt(press_nxt[i])
    );
  end

  assign up    = level_vec[BTN_UP];
  assign right = level_vec[BTN_RIGHT];
  assign down  = level_vec[BTN_DOWN];
  assign left  = level_vec[BTN_LEFT];

  dir_t dir_q, dir_d;
  logic dir_valid_q, dir_valid_d;

  // Driven by next-cycle press so dir lands on the same edge as the pulse.
  always_comb begin
    dir_d       = dir_q;
    dir_valid_d = dir_valid_q;
    if (|press_nxt) begin
      dir_d       = prio_dir(press_nxt);
      dir_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q       <= DIR_UP;
      dir_valid_q <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
    end
  end

  assign dir       = dir_q;
  assign dir_valid = dir_valid_q;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the start/ready gating logic and the pacman movement controller.
- Synchronises and debounces the four raw board direction buttons.
- Emits clean level signals (up/right/down/left), one-cycle press pulses, and a latched "last requested direction" for pacman steering.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronised cycles required before a level change is accepted (10 ms at 100 MHz); legal range ≥2.
- REPEAT_DELAY, 50000000, cycles of continuous hold before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-low (asserted when 0)
- btn_up_raw  in  1  raw asynchronous button
- btn_right_raw  in  1  raw asynchronous button
- btn_down_raw  in  1  raw asynchronous button
- btn_left_raw  in  1  raw asynchronous button
- up  out  1  debounced level
- right  out  1  debounced level
- down  out  1  debounced level
- left  out  1  debounced level
- press  out  4  one-cycle rise pulses; bit order {up,right,down,left} = [3:0]
- dir  out  2  last accepted direction: 0=up, 1=right, 2=down, 3=left
- dir_valid  out  1  set once any press has been accepted since reset

Behaviour:
- Reset (reset==0, asynchronous) clears:
  - all synchroniser flops, debounce counters and FSMs;
  - up/right/down/left, press, dir_valid to 0; dir to 0.
  - Deasserting reset mid-bounce restarts debouncing from STABLE_LOW.
- Synchroniser: 2 flops per button; nothing downstream uses raw inputs.
- Per-button debounce FSM, states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW:
  - STABLE_LOW: sync==1 → WAIT_HIGH, counter=0.
  - WAIT_HIGH: sync==1 → counter+1. If counter==DEBOUNCE_CYCLES-1 → STABLE_HIGH, level<=1, press pulse for exactly one cycle. sync==0 → STABLE_LOW, counter=0, no pulse.
  - STABLE_HIGH / WAIT_LOW: mirror image of the above. Falling acceptance clears the level; no pulse on release.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter saturates and never wraps.
- Latency: a clean raw rise sampled at edge N gives level=1 and press pulse registered at edge N+1+DEBOUNCE_CYCLES. This is 2 sync cycles plus DEBOUNCE_CYCLES-1 wait cycles; the transition edge itself is included in the count.
- Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no level change, no pulse.
- Direction latch (registered, same cycle as press):
  - any press bit set → dir updated, dir_valid<=1;
  - simultaneous presses resolved by priority up > right > down > left;
  - no press → dir holds, including after all buttons are released.
- Holding several buttons: only the newly accepted press changes dir. The held button never re-wins without a new press.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - each button in STABLE_HIGH runs a hold counter;
  - after REPEAT_DELAY cycles, press re-pulses for that button, then again every REPEAT_PERIOD cycles while held;
  - repeat pulses update dir under the same priority rule;
  - leaving STABLE_HIGH clears the hold counter.
- Undefined: no hold counters are synthesised; exactly one press pulse per accepted rise.

Decomposition:
- Package btn_pkg:
  - typedef enum logic[1:0] dir_t {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT};
  - typedef enum debounce state type;
  - bit-index constants BTN_UP=3, BTN_RIGHT=2, BTN_DOWN=1, BTN_LEFT=0.
- Sub-module btn_debounce: one button covering synchroniser, FSM, counter and optional repeat, instantiated 4×.
- Top level holds only the instances and the priority direction latch.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Hold reset=0, toggle all raw inputs → all outputs 0, dir=0, dir_valid=0 throughout.
- btn_right_raw rises at edge 10 and stays high → right=1, press=4'b0100 for one cycle at edge 15, dir=1, dir_valid=1. Release → right=0 four cycles after the synchronised fall; no pulse.
- btn_up_raw high for 2 cycles only → up stays 0, press stays 0, dir unchanged.
- btn_down_raw and btn_left_raw rise on the same edge → press=4'b0011 in one cycle, dir=2 (down beats left). Release both → dir stays 2.
- Hold left, then press up later → dir=3 then dir=0. Release up while left is still held → dir stays 0.
- With BTN_AUTOREPEAT_EN, hold right 30 cycles → press pulses at acceptance, +8, +11, +14 … cycles. Without the macro → a single pulse.
- Assert reset mid-WAIT_HIGH (counter=2), then release reset with the button held → a full 2+DEBOUNCE_CYCLES delay before right=1.
